inverse_result_collector: RTL and testbench

Downstream stage of the matrix inverter. Watches the inverter's `ready`/`invertible` outputs and captures the row-major inverse stream into an internal buffer. It then replays the buffer over a valid/ready stream, so the consumer can apply backpressure. The inverter cannot stall, so this block decouples it from the consumer and flags singular matrices.

---
 rtl/matinv_pkg.sv | 20 ++
 rtl/matinv_index_walker.sv | 64 ++++++
 rtl/inverse_result_collector.sv | 165 ++++++++++++++++
 tb/tb_inverse_result_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matinv_pkg.sv
// Shared definitions for the matrix inverter result path.
package matinv_pkg;
    localparam int MATINV_DATA_W    = 16;
    localparam int MATINV_MAX_ORDER = 16;
    localparam int IDX_W            = 4;          // row/col index width
    localparam int ORD_W            = IDX_W + 1;  // decoded order 1..16

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE,
        ST_SINGULAR
    } coll_state_e;

    // Order field 0 stands for the maximum order of 16.
    function automatic logic [ORD_W-1:0] order_decode(input logic [IDX_W-1:0] ord);
        return (ord == '0) ? ORD_W'(16) : {1'b0, ord};
    endfunction
endpackage

// File: rtl/matinv_index_walker.sv
// (row,col) pointer over an n x n matrix, row- or column-major walk,
// exposing both the current and the next position with their last flags.
module matinv_index_walker
    import matinv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic [ORD_W-1:0] n_i,
    input  logic             col_major_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o,
    output logic [IDX_W-1:0] nxt_row_o,
    output logic [IDX_W-1:0] nxt_col_o,
    output logic             nxt_last_o
);
    logic [IDX_W-1:0] row_q, col_q, row_d, col_d;
    logic [ORD_W-1:0] nm1;
    logic             row_end, col_end;

    assign nm1     = n_i - ORD_W'(1);
    assign row_end = ({1'b0, row_q} == nm1);
    assign col_end = ({1'b0, col_q} == nm1);

    // Next position: inner index advances first and wraps at n-1.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (col_major_i) begin
            if (row_end) begin
                row_d = '0;
                col_d = col_end ? '0 : col_q + IDX_W'(1);
            end else begin
                row_d = row_q + IDX_W'(1);
            end
        end else begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    // Pointer register, moves only when asked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (adv_i) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign last_o     = row_end && col_end;
    assign nxt_row_o  = row_d;
    assign nxt_col_o  = col_d;
    assign nxt_last_o = ({1'b0, row_d} == nm1) && ({1'b0, col_d} == nm1);
endmodule

// File: rtl/inverse_result_collector.sv
// Captures the inverter's row-major result stream into a buffer and replays
// it on a registered valid/ready stream; flags singular matrices.
module inverse_result_collector
    import matinv_pkg::*;
#(
    parameter int DATA_W    = MATINV_DATA_W,
    parameter int MAX_ORDER = MATINV_MAX_ORDER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  order,
    input  logic              col_major,
    input  logic [DATA_W-1:0] inv_data,
    input  logic              inv_ready,
    input  logic              inv_invertible,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_row,
    output logic [IDX_W-1:0]  m_col,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              singular
);
    coll_state_e       state_q, state_d;
    logic [ORD_W-1:0]  n_q, n_d, n_eff;
    logic              cm_q, cm_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              wr_en, w_adv, r_adv;
    logic [IDX_W-1:0]  w_row, w_col, r_row, r_col, r_nrow, r_ncol;
    logic              w_last, r_nlast;
    logic [IDX_W-1:0]  w_unused_nrow, w_unused_ncol;
    logic              w_unused_nlast, r_unused_last;

    logic [DATA_W-1:0] buf_mem_q [MAX_ORDER*MAX_ORDER];

    // While idle the order is not latched yet, so the write walker sees it live.
    assign n_eff = (state_q == ST_IDLE) ? order_decode(order) : n_q;

    matinv_index_walker u_wr_ptr (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (w_adv),
        .n_i        (n_eff),
        .col_major_i(1'b0),
        .row_o      (w_row),
        .col_o      (w_col),
        .last_o     (w_last),
        .nxt_row_o  (w_unused_nrow),
        .nxt_col_o  (w_unused_ncol),
        .nxt_last_o (w_unused_nlast)
    );

    matinv_index_walker u_rd_ptr (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (r_adv),
        .n_i        (n_q),
        .col_major_i(cm_q),
        .row_o      (r_row),
        .col_o      (r_col),
        .last_o     (r_unused_last),
        .nxt_row_o  (r_nrow),
        .nxt_col_o  (r_ncol),
        .nxt_last_o (r_nlast)
    );

    // Element buffer; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem_q[{w_row, w_col}] <= inv_data;
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cm_d      = cm_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        wr_en     = 1'b0;
        w_adv     = 1'b0;
        r_adv     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (inv_ready) begin
                    n_d  = n_eff;
                    cm_d = col_major;
                    if (!inv_invertible) begin
                        state_d = ST_SINGULAR;
                    end else begin
                        wr_en = 1'b1;
                        w_adv = 1'b1;
                        if (w_last) begin
                            // Order 1: the only element bypasses the buffer.
                            state_d   = ST_DRAIN;
                            m_valid_d = 1'b1;
                            m_last_d  = 1'b1;
                            m_data_d  = inv_data;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (inv_ready) begin
                    wr_en = 1'b1;
                    w_adv = 1'b1;
                    if (w_last) begin
                        // Element (0,0) was written long ago; present it.
                        state_d   = ST_DRAIN;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        m_data_d  = buf_mem_q[0];
                    end
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        state_d   = ST_DONE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        r_adv    = 1'b1;
                        m_data_d = buf_mem_q[{r_nrow, r_ncol}];
                        m_last_d = r_nlast;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            n_q       <= ORD_W'(16);
            cm_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cm_q      <= cm_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_row    = r_row;
    assign m_col    = r_col;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign busy     = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign singular = (state_q == ST_SINGULAR);
endmodule

// File: tb/tb_inverse_result_collector.sv
// Scoreboard bench: the model pushes the expected replay sequence, a monitor
// pops it on every handshake and also watches stall stability and completion.
module tb_inverse_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  order = 4'd0;
    logic        col_major = 1'b0;
    logic [15:0] inv_data = 16'd0;
    logic        inv_ready = 1'b0;
    logic        inv_invertible = 1'b1;
    logic [15:0] m_data;
    logic [3:0]  m_row, m_col;
    logic        m_valid, m_last, busy, done, singular;
    logic        m_ready = 1'b1;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  r;
        logic [3:0]  c;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] stim_data [256];
    int          n_chk = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    int          rdy_mode = 0;

    inverse_result_collector #(.DATA_W(16), .MAX_ORDER(16)) dut (
        .clk(clk), .rst(rst), .order(order), .col_major(col_major),
        .inv_data(inv_data), .inv_ready(inv_ready), .inv_invertible(inv_invertible),
        .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
        .singular(singular)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected replay: visit the n x n matrix in the selected order.
    task automatic model_push(input int n, input bit cm);
        exp_t e;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++) begin
                int r, c;
                r = cm ? b : a;
                c = cm ? a : b;
                e.d = stim_data[r*n + c];
                e.r = 4'(r);
                e.c = 4'(c);
                e.l = (a == n-1) && (b == n-1);
                sb.push_back(e);
            end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        stall = 1'b0;
        logic        chkd = 1'b0;
        logic [24:0] prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
                chkd  = 1'b0;
            end else begin
                if (chkd) begin
                    check("done_after_last", 32'(done), 32'd1);
                    check("valid_after_last", 32'(m_valid), 32'd0);
                    chkd = 1'b0;
                end
                if (stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_hold", 32'({m_data, m_row, m_col, m_last}), 32'(prev));
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: data %0h with empty scoreboard", m_data);
                    end else begin
                        e = sb.pop_front();
                        check("m_data", 32'(m_data), 32'(e.d));
                        check("m_row", 32'(m_row), 32'(e.r));
                        check("m_col", 32'(m_col), 32'(e.c));
                        check("m_last", 32'(m_last), 32'(e.l));
                        if (e.l) chkd = 1'b1;
                    end
                    xfer_cnt++;
                end
                stall = m_valid && !m_ready;
                prev  = {m_data, m_row, m_col, m_last};
            end
        end
    endtask

    task automatic ready_drv();
        int pc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_ready = (pc % 3 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            pc++;
        end
    endtask

    task automatic drive_cycle(input logic rdy, input logic [15:0] d);
        @(posedge clk);
        #1;
        inv_ready = rdy;
        inv_data  = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        inv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_last"}, 32'(m_last), 32'd0);
        check({tag, "_data"}, 32'(m_data), 32'd0);
        check({tag, "_rowcol"}, 32'({m_row, m_col}), 32'd0);
        check({tag, "_flags"}, 32'({busy, done, singular}), 32'd0);
    endtask

    // Feed the inverter stream, then check m_valid rises right after the last write.
    task automatic capture(input int ord, input bit cm, input bit gaps);
        int n;
        n = (ord == 0) ? 16 : ord;
        order = 4'(ord);
        col_major = cm;
        inv_invertible = 1'b1;
        model_push(n, cm);
        for (int k = 0; k < n*n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 16'($urandom));
            drive_cycle(1'b1, stim_data[k]);
        end
        drive_cycle(1'b0, 16'd0);
        @(negedge clk);
        check("valid_rise", 32'(m_valid), 32'd1);
        check("busy_drain", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic fill_random(input int cnt);
        for (int k = 0; k < cnt; k++) stim_data[k] = 16'($urandom);
    endtask

    initial begin
        int base, t;
        fork
            monitor();
            ready_drv();
        join_none

        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");

        // order 2, row-major, full-rate consumer
        stim_data[0] = 16'd3; stim_data[1] = 16'd5; stim_data[2] = 16'd7; stim_data[3] = 16'd9;
        rdy_mode = 0;
        capture(2, 1'b0, 1'b0);
        wait_done();

        // same data, column-major walk
        do_reset();
        capture(2, 1'b1, 1'b0);
        wait_done();

        // order 3 with periodic backpressure and capture gaps
        do_reset();
        fill_random(9);
        rdy_mode = 1;
        capture(3, 1'b0, 1'b1);
        wait_done();

        // singular matrix
        do_reset();
        rdy_mode = 0;
        order = 4'd3;
        inv_invertible = 1'b0;
        drive_cycle(1'b1, 16'h1234);
        drive_cycle(1'b0, 16'd0);
        @(negedge clk);
        check("singular_set", 32'({singular, m_valid, done, busy}), 32'b1000);
        inv_invertible = 1'b1;
        repeat (4) drive_cycle(1'b1, 16'($urandom));
        drive_cycle(1'b0, 16'd0);
        @(negedge clk);
        check("singular_hold", 32'({singular, m_valid, done, busy}), 32'b1000);

        // order 1: single element straight to drain
        do_reset();
        stim_data[0] = 16'h00FF;
        capture(1, 1'b0, 1'b0);
        wait_done();

        // order 16, reset after 100 transfers
        do_reset();
        fill_random(256);
        rdy_mode = 2;
        base = xfer_cnt;
        capture(0, 1'($urandom_range(0, 1)), 1'b1);
        t = 0;
        while ((xfer_cnt - base) < 100 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reached_100", 32'(xfer_cnt - base >= 100), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        inv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fill_random(64);
        capture(8, 1'b1, 1'b1);
        wait_done();

        // random orders and directions
        for (int i = 0; i < 3; i++) begin
            do_reset();
            fill_random(256);
            capture($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
